pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_decoder_sync_edge_detect.sv | 44 ++++
 rtl/pwm_decoder.sv | 173 +++++++++++++++++
 tb/tb_pwm_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: decoder FSM encoding, decoder defaults and the
// dimmer timing constants the decoder is normally pointed at.
package pwm_pkg;

    // Decoder defaults
    localparam int PWM_CNT_W_DEF       = 16;
    localparam int PWM_SYNC_STAGES_DEF = 2;

    // Dimmer output: fixed 16-cycle frame, duty programmable in whole cycles
    localparam int DIM_PERIOD_CYCLES = 16;
    localparam int DIM_MIN_HIGH      = 1;
    localparam int DIM_MAX_HIGH      = DIM_PERIOD_CYCLES - 1;

    // Decoder measurement states
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2,
        STUCK     = 2'd3
    } pwm_state_e;

    // Clamp a requested dimmer high time into the range the dimmer can emit,
    // so the waveform always has at least one high and one low cycle.
    function automatic int dim_clamp_high(input int req_high);
        if (req_high < DIM_MIN_HIGH) begin
            return DIM_MIN_HIGH;
        end
        if (req_high > DIM_MAX_HIGH) begin
            return DIM_MAX_HIGH;
        end
        return req_high;
    endfunction

endpackage

// File: rtl/pwm_decoder_sync_edge_detect.sv
// Synchroniser for the asynchronous PWM input followed by a single
// edge-detect register. rise/fall are combinational from the synced level
// and the previous synced level, so they are valid in the cycle after the
// level reaches the end of the synchroniser chain.
module sync_edge_detect
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the raw input through the chain; remember the last synced level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-detect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures period (rise to rise) and high time of an
// asynchronous PWM input in clk cycles, flags a stuck waveform.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_RISE | no reference rise yet; counter held at 0
// HIGH      | input high, counting; fall latches the high time
// LOW       | input low, counting; rise publishes period/high_time
// STUCK     | counter saturated; timeout set until the next edge
//
// The counter is loaded with 1 in the cycle a rise is detected, so on the
// next rise it holds exactly the number of cycles between the two rises.
// A fall in the cycle right after a rise therefore measures high_time = 1.
// valid is registered from the combinational rise, giving a fixed latency
// of SYNC_STAGES+1 clock edges counted from the edge that first samples
// the new pwm_in level.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W_DEF,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic level;
    logic rise;
    logic fall;

    pwm_state_e       state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [CNT_W-1:0] hi_lat_q,      hi_lat_d;
    logic [CNT_W-1:0] period_q,      period_d;
    logic [CNT_W-1:0] high_time_q,   high_time_d;
    logic             valid_q,       valid_d;
    logic             timeout_q,     timeout_d;
    logic             stuck_level_q, stuck_level_d;

    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    assign cnt_sat = (cnt_q == CNT_MAX);
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state, counter and output-register update
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_lat_d      = hi_lat_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        valid_d       = 1'b0;
        timeout_d     = timeout_q;
        stuck_level_d = stuck_level_q;

        case (state_q)
            WAIT_RISE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = HIGH;
                end
            end

            HIGH: begin
                // Saturation wins over a coincident fall: a high time of
                // CNT_MAX would leave no room for a larger period.
                if (cnt_sat) begin
                    state_d       = STUCK;
                    timeout_d     = 1'b1;
                    stuck_level_d = level;
                end else if (fall) begin
                    hi_lat_d = cnt_q;
                    cnt_d    = cnt_inc;
                    state_d  = LOW;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            LOW: begin
                // A rise on the saturated count is still a legal period.
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_lat_q;
                    valid_d     = 1'b1;
                    cnt_d       = CNT_ONE;
                    state_d     = HIGH;
                end else if (cnt_sat) begin
                    state_d       = STUCK;
                    timeout_d     = 1'b1;
                    stuck_level_d = level;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            STUCK: begin
                // A rise here starts a fresh period; its measurement is
                // published on the following rise.
                if (rise) begin
                    cnt_d         = CNT_ONE;
                    timeout_d     = 1'b0;
                    stuck_level_d = 1'b0;
                    state_d       = HIGH;
                end else if (fall) begin
                    cnt_d         = '0;
                    timeout_d     = 1'b0;
                    stuck_level_d = 1'b0;
                    state_d       = WAIT_RISE;
                end
            end

            default: begin
                cnt_d         = '0;
                timeout_d     = 1'b0;
                stuck_level_d = 1'b0;
                state_d       = WAIT_RISE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_RISE;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_decoder.sv
`timescale 1ns/1ps
// Directed bench for pwm_decoder: tick waveform, duty change, reset while
// high, stuck-high and stuck-low timeouts with an 8-bit counter.
module tb_pwm_decoder;
    import pwm_pkg::*;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             stuck_level;

    pwm_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        int hi;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    bit   have_prev = 1'b0;
    int   prev_per = 0;
    int   prev_hi = 0;
    int   p_mark = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every valid pulse must match the oldest outstanding expectation,
    // including the cycle it appears on.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            chk("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("valid_period", 32'(period), mon_e.per);
                chk("valid_high", 32'(high_time), mon_e.hi);
                chk("valid_latency", cyc, mon_e.at);
            end
        end
    end

    task automatic drive(input logic lvl, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = lvl;
        end
    endtask

    // Rising edge of pwm_in; it closes the previous period if there is one.
    // The edge at posedge cyc+1 samples it, valid shows after posedge cyc+SYNC+1.
    task automatic rise_edge();
        @(negedge clk);
        pwm_in = 1'b1;
        p_mark = cyc;
        if (have_prev) begin
            sb.push_back('{per: prev_per, hi: prev_hi, at: cyc + SYNC + 1});
        end
    endtask

    task automatic run_period(input int hi, input int lo);
        rise_edge();
        drive(1'b1, hi - 1);
        drive(1'b0, lo);
        have_prev = 1'b1;
        prev_per  = hi + lo;
        prev_hi   = hi;
    endtask

    task automatic close_run();
        rise_edge();
        drive(1'b1, 8);
        have_prev = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        drive(1'b0, 3);
        rst_n     = 1'b1;
        have_prev = 1'b0;
        drive(1'b0, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        drive(1'b0, 3);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high", 32'(high_time), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_stuck", 32'(stuck_level), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(WAIT_RISE));
        rst_n = 1'b1;
        drive(1'b0, 3);

        // Tick generator: high 1, low 15
        repeat (5) run_period(1, 15);
        close_run();
        chk("tick_sb_drained", sb.size(), 32'd0);
        chk("tick_hold_period", 32'(period), 32'd16);
        chk("tick_hold_high", 32'(high_time), 32'd1);

        // Duty 4/16 then 10/16
        do_reset();
        repeat (4) run_period(4, 12);
        repeat (3) run_period(10, 6);
        close_run();
        chk("duty_sb_drained", sb.size(), 32'd0);
        chk("duty_hold_period", 32'(period), 32'd16);
        chk("duty_hold_high", 32'(high_time), 32'd10);
        chk("duty_valid_low", 32'(valid), 32'd0);

        // Reset while in HIGH
        do_reset();
        run_period(4, 12);
        run_period(4, 12);
        rise_edge();
        drive(1'b1, 4);
        chk("prerst_state", 32'(dut.state_q), 32'(HIGH));
        chk("prerst_period", 32'(period), 32'd16);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #1;
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_high", 32'(high_time), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        chk("midrst_stuck", 32'(stuck_level), 32'd0);
        drive(1'b0, 3);
        rst_n     = 1'b1;
        have_prev = 1'b0;
        drive(1'b0, 3);
        run_period(4, 12);
        chk("one_rise_period", 32'(period), 32'd0);
        chk("one_rise_high", 32'(high_time), 32'd0);
        close_run();
        chk("rst_sb_drained", sb.size(), 32'd0);
        chk("rst_after_period", 32'(period), 32'd16);

        // Stuck high: counter saturates at 255 after the rise
        do_reset();
        rise_edge();
        drive(1'b1, 257);
        chk("sthi_before_timeout", 32'(timeout), 32'd0);
        drive(1'b1, 1);
        chk("sthi_timeout", 32'(timeout), 32'd1);
        chk("sthi_stuck_level", 32'(stuck_level), 32'd1);
        chk("sthi_period", 32'(period), 32'd0);
        drive(1'b0, 1);
        drive(1'b0, 2);
        chk("sthi_timeout_held", 32'(timeout), 32'd1);
        drive(1'b0, 1);
        chk("sthi_timeout_clr", 32'(timeout), 32'd0);
        chk("sthi_stuck_clr", 32'(stuck_level), 32'd0);
        chk("sthi_state", 32'(dut.state_q), 32'(WAIT_RISE));
        have_prev = 1'b0;
        run_period(4, 12);
        close_run();
        chk("sthi_sb_drained", sb.size(), 32'd0);

        // Stuck low after one measured high, then a rise restarts counting
        do_reset();
        rise_edge();
        drive(1'b1, 3);
        drive(1'b0, 254);
        chk("stlo_before_timeout", 32'(timeout), 32'd0);
        drive(1'b0, 1);
        chk("stlo_timeout", 32'(timeout), 32'd1);
        chk("stlo_stuck_level", 32'(stuck_level), 32'd0);
        chk("stlo_state", 32'(dut.state_q), 32'(STUCK));
        have_prev = 1'b0;
        run_period(4, 12);
        chk("stlo_timeout_clr", 32'(timeout), 32'd0);
        chk("stlo_no_valid_period", 32'(period), 32'd0);
        close_run();
        chk("stlo_sb_drained", sb.size(), 32'd0);
        chk("stlo_period", 32'(period), 32'd16);
        chk("stlo_high", 32'(high_time), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
